tcb_img_loader: RTL and testbench
=================================

Name: tcb_img_loader

Overview:
- Upstream feeder for the TCB 121-16-10 network top.
- Accepts a serial stream of 8-bit pixels of an 11x11 down-sampled Fashion-MNIST image, with a valid/ready handshake and an end-of-frame flag.
- Packs the pixels into the 121*8-bit image bus and issues one start pulse per frame to the network.
- Holds the image stable until the network's done pulse, and captures the predicted class.
- Contains a fill buffer and an issue buffer, so the next frame loads while the network computes the current one.

Parameters:
- NPIX, 121, pixels per frame (11x11).
- PW, 8, bits per pixel.
- CW, 7, width of pixel counter; must satisfy 2^CW > NPIX.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- pix_data  input  PW  incoming pixel.
- pix_valid  input  1  pixel present.
- pix_last  input  1  marks the final pixel of a frame; qualified by pix_valid.
- pix_ready  output  1  loader can accept a pixel this cycle.
- img_source  output  NPIX*PW  packed image to the network; pixel k occupies bits [k*PW +: PW], k=0 is the first pixel received.
- valid_top  output  1  one-cycle start pulse to the network.
- ready_top  input  1  network done pulse (one cycle).
- number  input  32  network prediction, valid when ready_top=1.
- result  output  32  last captured prediction.
- result_valid  output  1  one-cycle pulse when result updates.
- frame_err  output  1  sticky framing-error flag; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0 except pix_ready, which goes to 1.
  - Fill buffer, issue buffer, counter, result and frame_err clear.
  - Network-busy flag clears.
  - Reset mid-frame or mid-inference discards everything.
  - A ready_top arriving after reset while the loader is idle is ignored.
- Pixel accept:
  - A pixel is accepted when pix_valid && pix_ready.
  - It is written to fill slot cnt, then cnt increments.
- Fill FSM states: FILL, FULL.
- FILL, pix_ready=1:
  - Accepted pixel with cnt==NPIX-1 and pix_last=1 -> FULL.
  - Accepted pixel with pix_last=1 and cnt<NPIX-1 (short frame):
    - Set frame_err.
    - Reset cnt to 0.
    - Drop the frame; stay in FILL.
  - Accepted pixel with cnt==NPIX-1 and pix_last=0 (long frame):
    - Set frame_err.
    - Reset cnt to 0.
    - Drop the frame.
    - Subsequent pixels are treated as a new frame.
- FULL, pix_ready=0:
  - If the network is not busy, or ready_top=1 this cycle:
    - Copy the fill buffer to img_source.
    - Assert valid_top for exactly one cycle, on the following cycle.
    - Set busy; reset cnt to 0.
    - Return to FILL; pix_ready=1 on the next cycle.
- Issue latency:
  - The final pixel is accepted at edge N.
  - With the network idle, img_source is updated at edge N+1, and valid_top=1 in the cycle after edge N+1.
  - Minimum frame period is 121 accept cycles + 1 issue cycle.
- img_source is held constant from issue until the next issue; it never changes while busy=1.
- Completion:
  - ready_top=1 while busy:
    - Capture number into result; pulse result_valid one cycle later.
    - Clear busy, unless a new issue occurs in the same cycle, in which case busy stays set.
- Simultaneous events:
  - A FULL-to-issue transition and ready_top in the same cycle:
    - Capture the result and issue the new frame in that cycle.
    - result_valid and valid_top pulse in the same cycle.
- Protocol rules:
  - pix_data and pix_last are ignored when pix_valid=0.
  - The upstream must hold pix_data while pix_valid=1 and pix_ready=0.
  - frame_err does not stall the datapath.

Test Plan:
- Reset with rst=0 for 3 cycles:
  - Required: pix_ready=1, valid_top=0, img_source=0, result=0, frame_err=0.
- Single frame, pixel k = k (0..120), pix_last on k=120, network idle:
  - Required: one valid_top pulse two cycles after the last accept; img_source[k*8+:8]=k for all k.
  - Then ready_top=1 with number=7 -> result=7 and a one-cycle result_valid pulse.
- Back-to-back frames A (all 0x11) and B (all 0x22), with ready_top delayed 300 cycles after A's start:
  - Required: B fills fully, then pix_ready=0; img_source stays 0x11.. until ready_top.
  - Required: B's valid_top occurs in the cycle after ready_top.
- Short frame, pix_last on pixel 50:
  - Required: frame_err=1, no valid_top; a following correct 121-pixel frame issues normally.
- Long frame, pix_last=0 at pixel 120:
  - Required: frame_err=1, no issue, cnt restarts at 0.
- rst=0 asserted at pixel 60, then a clean frame:
  - Required: the partial frame is discarded and the clean frame issues with exact contents.
  - Required: a stray ready_top before any issue leaves result=0 and result_valid=0.

Source files
------------

// File: rtl/tcb_img_loader.sv
// Purpose : packs a serial 8-bit pixel stream into the 121-pixel image bus and starts the network once per frame.
// Latency : last pixel accepted at edge N -> img_source loaded at edge N+1, valid_top high in the following cycle.
// Backpr. : pix_ready drops while a complete frame waits for the network; it rises again the cycle after issue.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   pix_data/valid/last upstream pixel stream (valid/ready), pix_last marks the final pixel
//   pix_ready           loader can take a pixel this cycle
//   img_source          packed image, pixel k at [k*PW +: PW]
//   valid_top           one-cycle network start pulse
//   ready_top, number   network done pulse and its prediction
//   result/result_valid last captured prediction and its update pulse
//   frame_err           sticky short/long frame flag
module tcb_img_loader #(
  parameter int NPIX = 121,
  parameter int PW   = 8,
  parameter int CW   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        pix_data,
  input  logic                 pix_valid,
  input  logic                 pix_last,
  output logic                 pix_ready,
  output logic [NPIX*PW-1:0]   img_source,
  output logic                 valid_top,
  input  logic                 ready_top,
  input  logic [31:0]          number,
  output logic [31:0]          result,
  output logic                 result_valid,
  output logic                 frame_err
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NPIX*PW-1:0]  fill_buf;
  logic                busy;
  logic                accept;
  logic                issue;
  logic                err_set;

  assign pix_ready = (state == FILL);
  assign accept    = pix_valid && pix_ready;

  // State and pixel counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    err_set   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (cnt == LAST_IDX) begin
            // Frame-length boundary: either a clean end or a long frame.
            cnt_nxt = '0;
            if (pix_last) begin
              state_nxt = FULL;
            end else begin
              err_set = 1'b1;
            end
          end else if (pix_last) begin
            // Short frame: drop it and restart at slot 0.
            err_set = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      FULL: begin
        // A done pulse frees the network in the same cycle, so the next
        // frame can be issued without waiting for busy to clear.
        if (!busy || ready_top) begin
          issue     = 1'b1;
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath: fill buffer, issue buffer, result capture and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_buf     <= '0;
      img_source   <= '0;
      valid_top    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (accept) begin
        fill_buf[cnt*PW +: PW] <= pix_data;
      end

      valid_top <= issue;
      if (issue) begin
        img_source <= fill_buf;
      end

      // ready_top is only meaningful while an inference is outstanding.
      result_valid <= ready_top && busy;
      if (ready_top && busy) begin
        result <= number;
      end

      if (issue) begin
        busy <= 1'b1;
      end else if (ready_top) begin
        busy <= 1'b0;
      end

      if (err_set) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcb_img_loader.sv
// Scoreboard bench for tcb_img_loader: stimulus pushes expected images/results,
// a negedge monitor pops and compares on every valid_top / result_valid pulse.
module tb_tcb_img_loader;

  localparam int NPIX = 121;
  localparam int PW   = 8;
  localparam int W    = NPIX * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [W-1:0]  img_source;
  logic          valid_top;
  logic          ready_top;
  logic [31:0]   number;
  logic [31:0]   result;
  logic          result_valid;
  logic          frame_err;

  tcb_img_loader #(.NPIX(NPIX), .PW(PW), .CW(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .img_source   (img_source),
    .valid_top    (valid_top),
    .ready_top    (ready_top),
    .number       (number),
    .result       (result),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] img_q[$];
  logic [31:0]  res_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int vt_count = 0;
  int rv_count = 0;
  int vt_cyc = 0;
  int rv_cyc = 0;
  int last_acc = 0;
  int rt_edge = 0;
  int a_vt_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int kind, input int k);
    case (kind)
      0:       return 8'(k);
      1:       return 8'h11;
      2:       return 8'h22;
      3:       return 8'(k) ^ 8'h5A;
      4:       return 8'(255 - k);
      5:       return 8'(k + 3);
      default: return 8'(k * 7);
    endcase
  endfunction

  function automatic logic [W-1:0] img_of(input int kind);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NPIX; k++) v[k*PW +: PW] = pix_of(kind, k);
    return v;
  endfunction

  // Monitor: compares every output event against the scoreboard queues.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    int bad;
    if (valid_top === 1'b1) begin
      vt_count++;
      vt_cyc = cyc;
      n_chk++;
      if (img_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid_top: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = img_q.pop_front();
        if (img_source !== e) begin
          bad = 0;
          for (int k = 0; k < NPIX; k++) begin
            if (img_source[k*PW +: PW] !== e[k*PW +: PW]) begin
              bad = k;
              break;
            end
          end
          n_fail++;
          $display("FAIL img_source pixel %0d: got %0h expected %0h",
                   bad, img_source[bad*PW +: PW], e[bad*PW +: PW]);
        end
      end
    end
    if (result_valid === 1'b1) begin
      rv_count++;
      rv_cyc = cyc;
      n_chk++;
      if (res_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result_valid: got result %0h expected no pulse", result);
      end else begin
        e[31:0] = res_q.pop_front();
        if (result !== e[31:0]) begin
          n_fail++;
          $display("FAIL result: got %0h expected %0h", result, e[31:0]);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send_pix(input logic [7:0] d, input logic l);
    int b;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    b = 0;
    while (!pix_ready && b < 1000) begin
      @(posedge clk); #1;
      b++;
    end
    if (!pix_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL pix_ready_wait: got 0 expected 1 within 1000 cycles");
      pix_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
  endtask

  task automatic send_frame(input int kind, input int n, input int last_at);
    for (int k = 0; k < n; k++) send_pix(pix_of(kind, k), k == last_at);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic pulse_rt(input logic [31:0] num, input bit expect_res);
    number    = num;
    ready_top = 1'b1;
    if (expect_res) res_q.push_back(num);
    @(posedge clk); #1;
    rt_edge   = cyc;
    ready_top = 1'b0;
  endtask

  task automatic wait_vt(input int target);
    int b = 0;
    while (vt_count < target && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("valid_top_count", vt_count, target);
  endtask

  task automatic wait_rv(input int target);
    int b = 0;
    while (rv_count < target && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("result_valid_count", rv_count, target);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    ready_top = 1'b0;
    number    = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_valid_top", valid_top, 0);
    chk("rst_img_zero", (img_source === '0) ? 1 : 0, 1);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frame, pixel k = k.
    img_q.push_back(img_of(0));
    send_frame(0, NPIX, NPIX - 1);
    wait_vt(1);
    chk("issue_latency_1", vt_cyc, last_acc + 1);
    chk("pix_ready_after_issue", pix_ready, 1);
    pulse_rt(32'd7, 1'b1);
    wait_rv(1);
    chk("result_latency", rv_cyc, rt_edge);
    chk("result_7", result, 32'd7);
    @(posedge clk); #1;
    chk("result_valid_one_cycle", result_valid, 0);

    // Back-to-back frames A (0x11) and B (0x22) with delayed done.
    img_q.push_back(img_of(1));
    send_frame(1, NPIX, NPIX - 1);
    wait_vt(2);
    a_vt_cyc = vt_cyc;
    img_q.push_back(img_of(2));
    send_frame(2, NPIX, NPIX - 1);
    while (cyc < a_vt_cyc + 300) @(posedge clk);
    #1;
    chk("b_full_stall", pix_ready, 0);
    chk("hold_img_a", (img_source === img_of(1)) ? 1 : 0, 1);
    chk("no_early_issue_b", vt_count, 2);
    pulse_rt(32'd3, 1'b1);
    wait_vt(3);
    wait_rv(2);
    chk("b_issue_after_rt", vt_cyc, rt_edge);
    chk("rv_with_vt", rv_cyc, rt_edge);
    pulse_rt(32'd9, 1'b1);
    wait_rv(3);

    // Short frame, then a good frame.
    send_frame(5, 51, 50);
    repeat (5) @(posedge clk);
    #1;
    chk("short_frame_err", frame_err, 1);
    chk("short_no_issue", vt_count, 3);
    chk("short_pix_ready", pix_ready, 1);
    img_q.push_back(img_of(3));
    send_frame(3, NPIX, NPIX - 1);
    wait_vt(4);
    chk("issue_latency_after_short", vt_cyc, last_acc + 1);
    pulse_rt(32'h55, 1'b1);
    wait_rv(4);

    // Long frame after a fresh reset, then a good frame.
    do_reset(2);
    chk("reset_clears_err", frame_err, 0);
    chk("reset_clears_result", result, 0);
    send_frame(5, NPIX, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("long_frame_err", frame_err, 1);
    chk("long_no_issue", vt_count, 4);
    chk("long_pix_ready", pix_ready, 1);
    img_q.push_back(img_of(4));
    send_frame(4, NPIX, NPIX - 1);
    wait_vt(5);
    chk("issue_latency_after_long", vt_cyc, last_acc + 1);
    pulse_rt(32'd100, 1'b1);
    wait_rv(5);

    // Reset mid-frame, stray done pulse, then a clean frame.
    send_frame(0, 60, -1);
    do_reset(2);
    chk("midreset_pix_ready", pix_ready, 1);
    chk("midreset_err", frame_err, 0);
    pulse_rt(32'hDEAD, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("stray_rt_result", result, 0);
    chk("stray_rt_no_rv", rv_count, 5);
    chk("stray_rt_no_issue", vt_count, 5);
    img_q.push_back(img_of(6));
    send_frame(6, NPIX, NPIX - 1);
    wait_vt(6);
    chk("issue_latency_clean", vt_cyc, last_acc + 1);
    pulse_rt(32'h12345678, 1'b1);
    wait_rv(6);
    repeat (3) @(posedge clk);
    #1;

    chk("img_q_empty", img_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    chk("total_valid_top", vt_count, 6);
    chk("total_result_valid", rv_count, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
